arm_fetch: RTL and testbench

Instruction-fetch front end of the ARM core. It owns the program counter and issues word reads to the instruction memory, which has one-cycle synchronous read latency. Returned instructions go into a 2-entry prefetch queue that feeds decode over a valid/ready handshake. Branch redirects flush the queue. Fetching stops when the PC leaves the program image, which is the same `pc >= INS_MEM_SIZE*4` end-of-program condition the system benches poll.

---
 rtl/arm_fetch.sv | 120 ++++++++++++
 tb/tb_arm_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_fetch.sv
// Instruction-fetch front end: owns the PC, issues one-cycle-latency word reads
// and buffers returned instructions in a 2-entry queue feeding decode.
module arm_fetch #(
    parameter int INS_MEM_SIZE = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic        ins_valid,
    output logic [31:0] ins_data,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    output logic [31:0] pc,
    output logic        halted
);

    localparam logic [31:0] FETCH_LIMIT = 32'(INS_MEM_SIZE) << 2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] q_data [2];
    logic [31:0] q_pc   [2];
    logic        head;
    logic [1:0]  count;
    logic        inflight;
    logic [31:0] inflight_addr;

    logic        pop;
    logic        push;
    logic        tail;
    logic        credit_ok;
    logic        in_image;
    logic [31:0] br_pc;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ins_valid = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        tail      = 1'b0;
        credit_ok = 1'b0;
        in_image  = 1'b0;
        br_pc     = '0;
        imem_req  = 1'b0;
        ins_data  = '0;
        ins_pc    = '0;

        ins_valid = (count != 2'd0);
        pop       = ins_valid && ins_ready;
        // The response of the request issued last cycle arrives now; a branch drops it.
        push      = inflight && !br_valid;
        tail      = head ^ count[0];
        in_image  = (pc < FETCH_LIMIT);
        br_pc     = br_target & 32'hFFFF_FFFC;
        credit_ok = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        // Gating with rst keeps the request low for the whole reset interval.
        imem_req  = rst && (state == RUN) && in_image && !br_valid && credit_ok;

        if (ins_valid) begin
            ins_data = q_data[head];
            ins_pc   = q_pc[head];
        end
    end

    assign imem_addr = pc;
    assign halted    = (state == DONE);

    // NOTE: control state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            pc            <= '0;
            head          <= 1'b0;
            count         <= 2'd0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (br_valid) begin
            pc       <= br_pc;
            head     <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
            state    <= (br_pc < FETCH_LIMIT) ? RUN : DRAIN;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc            <= pc + 32'd4;
                inflight_addr <= pc;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            head  <= head ^ pop;

            case (state)
                RUN:     if (!in_image) state <= DRAIN;
                DRAIN:   if (count == 2'd0 && !inflight) state <= DONE;
                default: state <= state;
            endcase
        end
    end

    // NOTE: queue storage is not reset; count gates every read of it, so
    // stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= imem_rdata;
            q_pc[tail]   <= inflight_addr;
        end
    end

endmodule

// File: tb/tb_arm_fetch.sv
// Directed bench for arm_fetch: straight-line fetch, backpressure, branches,
// restart from DONE and asynchronous reset mid-stream.
module tb_arm_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready = 1'b1;
    logic [31:0] pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    arm_fetch #(.INS_MEM_SIZE(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .ins_valid  (ins_valid),
        .ins_data   (ins_data),
        .ins_pc     (ins_pc),
        .ins_ready  (ins_ready),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Program image: word i holds 0xE000_0000 + i.
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hE000_0000 + (addr >> 2);
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= word_at(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic bv, input logic [31:0] bt);
        ins_ready = rdy;
        br_valid  = bv;
        br_target = bt;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0, the first cycle after reset release.
    task automatic reset_dut(input logic rdy);
        rst = 1'b0;
        drive(rdy, 1'b0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] addr);
        check({tag, " valid"}, 32'(ins_valid), 32'd1);
        check({tag, " pc"}, ins_pc, addr);
        check({tag, " data"}, ins_data, word_at(addr));
    endtask

    initial begin
        // Reset values.
        rst = 1'b0;
        drive(1'b1, 1'b0, '0);
        @(posedge clk);
        #1;
        check("rst imem_req", 32'(imem_req), 32'd0);
        check("rst imem_addr", imem_addr, 32'd0);
        check("rst ins_valid", 32'(ins_valid), 32'd0);
        check("rst ins_data", ins_data, 32'd0);
        check("rst ins_pc", ins_pc, 32'd0);
        check("rst pc", pc, 32'd0);
        check("rst halted", 32'(halted), 32'd0);

        // Straight line, then restart from DONE with a branch to 0x10.
        reset_dut(1'b1);
        check("line c0 req", 32'(imem_req), 32'd1);
        check("line c0 addr", imem_addr, 32'd0);
        check("line c0 valid", 32'(ins_valid), 32'd0);
        for (int c = 1; c <= 39; c++) begin
            next_cycle();
            drive(1'b1, (c == 35), 32'h10);
            if (c <= 31) begin
                check($sformatf("line c%0d req", c), 32'(imem_req), 32'd1);
                check($sformatf("line c%0d addr", c), imem_addr, 32'(4 * c));
            end
            if (c == 1) check("line c1 valid", 32'(ins_valid), 32'd0);
            if (c >= 2 && c <= 33) expect_head($sformatf("line c%0d", c), 32'(4 * (c - 2)));
            if (c == 32) begin
                check("line pc end", pc, 32'd128);
                check("line req stop", 32'(imem_req), 32'd0);
            end
            if (c == 34) check("line not halted", 32'(halted), 32'd0);
            if (c == 35) begin
                check("line halted", 32'(halted), 32'd1);
                check("restart br req", 32'(imem_req), 32'd0);
            end
            if (c == 36) begin
                check("restart halted", 32'(halted), 32'd0);
                check("restart req", 32'(imem_req), 32'd1);
                check("restart addr", imem_addr, 32'h10);
            end
            if (c == 37) check("restart gap", 32'(ins_valid), 32'd0);
            if (c == 38) expect_head("restart head", 32'h10);
            if (c == 39) expect_head("restart next", 32'h14);
        end

        // Backpressure: decode stalls while the first two instructions arrive.
        reset_dut(1'b0);
        for (int c = 1; c <= 19; c++) begin
            next_cycle();
            drive((c >= 8), 1'b0, '0);
            if (c >= 3 && c <= 7) begin
                check($sformatf("bp c%0d req", c), 32'(imem_req), 32'd0);
                check($sformatf("bp c%0d pc", c), pc, 32'd8);
                expect_head($sformatf("bp c%0d hold", c), 32'd0);
            end
            if (c == 8) begin
                check("bp resume req", 32'(imem_req), 32'd1);
                check("bp resume addr", imem_addr, 32'd8);
            end
            if (c >= 8) expect_head($sformatf("bp c%0d", c), 32'(4 * (c - 8)));
        end

        // Branch in cycle 5 to an unaligned target.
        reset_dut(1'b1);
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            drive(1'b1, (c == 5), 32'h0000_0043);
            if (c == 5) begin
                check("br cycle req", 32'(imem_req), 32'd0);
                expect_head("br cycle pop", 32'd12);
            end
            if (c == 6) begin
                check("br b1 valid", 32'(ins_valid), 32'd0);
                check("br b1 req", 32'(imem_req), 32'd1);
                check("br b1 addr", imem_addr, 32'h40);
                check("br b1 pc", pc, 32'h40);
            end
            if (c == 7) begin
                check("br b2 valid", 32'(ins_valid), 32'd0);
                check("br b2 addr", imem_addr, 32'h44);
            end
            if (c == 8) expect_head("br b3 head", 32'h40);
            if (c == 9) expect_head("br b4 head", 32'h44);
        end

        // Branch and pop together with a full queue.
        reset_dut(1'b0);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            drive((c >= 4), (c == 4), 32'h20);
            if (c == 3) check("bpop full req", 32'(imem_req), 32'd0);
            if (c == 4) expect_head("bpop delivered", 32'd0);
            if (c == 5) begin
                check("bpop empty valid", 32'(ins_valid), 32'd0);
                check("bpop empty pc", ins_pc, 32'd0);
                check("bpop empty data", ins_data, 32'd0);
                check("bpop addr", imem_addr, 32'h20);
            end
            if (c == 6) check("bpop gap", 32'(ins_valid), 32'd0);
            if (c == 7) expect_head("bpop head", 32'h20);
            if (c == 8) expect_head("bpop next", 32'h24);
        end

        // Asynchronous reset in cycle 7 while fetching.
        reset_dut(1'b1);
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            drive(1'b1, 1'b0, '0);
        end
        expect_head("arst before", 32'd20);
        #1;
        rst = 1'b0;
        #1;
        check("arst valid", 32'(ins_valid), 32'd0);
        check("arst pc", pc, 32'd0);
        check("arst req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        check("arst hold req", 32'(imem_req), 32'd0);
        check("arst hold valid", 32'(ins_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst rel req", 32'(imem_req), 32'd1);
        check("arst rel addr", imem_addr, 32'd0);
        check("arst rel valid", 32'(ins_valid), 32'd0);
        next_cycle();
        check("arst c1 valid", 32'(ins_valid), 32'd0);
        check("arst c1 addr", imem_addr, 32'd4);
        next_cycle();
        expect_head("arst c2 head", 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
